matrix3x3_rinv_qt_multiply: RTL

Final stage of the 3x3 QR-based matrix inversion path. Consumes the upper-triangular R⁻¹ produced by the triangular-inverse stage and the orthogonal Q from the QR stage, and computes A⁻¹ = R⁻¹·Qᵀ. It uses a single time-shared multiplier-accumulator driven by a small FSM. It presents a start/done level handshake so it chains directly behind the upstream stage's `done`.

---
 rtl/matrix_inv_pkg.sv | 30 +++
 rtl/fxp_mac_unit.sv | 31 +++
 rtl/matrix3x3_rinv_qt_multiply.sv | 120 ++++++++++++
 3 files changed

// File: rtl/matrix_inv_pkg.sv
// rtl/matrix_inv_pkg.sv - shared widths, FSM state type and fixed-point saturate helper
// for the 3x3 matrix inversion path.
package matrix_inv_pkg;

  localparam int wordLength     = 16;
  localparam int fractionLength = 12;
  localparam int RINV_W         = 33;
  localparam int OUT_W          = 33;
  localparam int PROD_W         = RINV_W + wordLength;
  localparam int ACC_W          = PROD_W + 2;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } state_t;

  // Renormalise an accumulator back to R-inverse format, clamping to the signed OUT_W range.
  function automatic logic signed [OUT_W-1:0] sat_shift(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> fractionLength;
    if ((&sh[ACC_W-1:OUT_W-1]) || !(|sh[ACC_W-1:OUT_W-1]))
      return sh[OUT_W-1:0];
    else if (sh[ACC_W-1])
      return {1'b1, {(OUT_W-1){1'b0}}};
    else
      return {1'b0, {(OUT_W-1){1'b1}}};
  endfunction

endpackage

// File: rtl/fxp_mac_unit.sv
// rtl/fxp_mac_unit.sv - signed multiply-accumulate with clear-on-first-term and a
// combinational shifted/saturated result taken from the next accumulator value.
module fxp_mac_unit
  import matrix_inv_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     first,
  input  logic signed [RINV_W-1:0] a,
  input  logic signed [wordLength-1:0] b,
  output logic signed [OUT_W-1:0]  result
);

  logic signed [PROD_W-1:0] product;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_next;

  assign product  = PROD_W'(a) * PROD_W'(b);
  assign acc_next = (first ? ACC_W'(0) : acc) + ACC_W'(product);
  // Result reflects the term being added this cycle, so the caller can store it on the same edge.
  assign result   = sat_shift(acc_next);

  always_ff @(posedge clk) begin
    if (reset)
      acc <= '0;
    else if (en)
      acc <= acc_next;
  end

endmodule

// File: rtl/matrix3x3_rinv_qt_multiply.sv
// rtl/matrix3x3_rinv_qt_multiply.sv - computes A_inv = R_inv * Q^T with one shared MAC,
// skipping all lower-triangle R_inv terms (18 MAC cycles per run).
module matrix3x3_rinv_qt_multiply
  import matrix_inv_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic signed [RINV_W-1:0]     R11_inv,
  input  logic signed [RINV_W-1:0]     R12_inv,
  input  logic signed [RINV_W-1:0]     R13_inv,
  input  logic signed [RINV_W-1:0]     R22_inv,
  input  logic signed [RINV_W-1:0]     R23_inv,
  input  logic signed [RINV_W-1:0]     R33_inv,
  input  logic signed [wordLength-1:0] Q11,
  input  logic signed [wordLength-1:0] Q12,
  input  logic signed [wordLength-1:0] Q13,
  input  logic signed [wordLength-1:0] Q21,
  input  logic signed [wordLength-1:0] Q22,
  input  logic signed [wordLength-1:0] Q23,
  input  logic signed [wordLength-1:0] Q31,
  input  logic signed [wordLength-1:0] Q32,
  input  logic signed [wordLength-1:0] Q33,
  output logic signed [OUT_W-1:0]      A11_inv,
  output logic signed [OUT_W-1:0]      A12_inv,
  output logic signed [OUT_W-1:0]      A13_inv,
  output logic signed [OUT_W-1:0]      A21_inv,
  output logic signed [OUT_W-1:0]      A22_inv,
  output logic signed [OUT_W-1:0]      A23_inv,
  output logic signed [OUT_W-1:0]      A31_inv,
  output logic signed [OUT_W-1:0]      A32_inv,
  output logic signed [OUT_W-1:0]      A33_inv,
  output logic                         done
);

  state_t                      state;
  logic [1:0]                  i, j, k;
  logic signed [RINV_W-1:0]    r_cap [1:3][1:3];
  logic signed [wordLength-1:0] q_cap [1:3][1:3];
  logic signed [OUT_W-1:0]     a_inv [1:3][1:3];
  logic signed [OUT_W-1:0]     mac_result;

  fxp_mac_unit u_mac (
    .clk    (clk),
    .reset  (reset),
    .en     (state == MAC),
    .first  (k == i),
    .a      (r_cap[i][k]),
    .b      (q_cap[j][k]),
    .result (mac_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      i     <= 2'd1;
      j     <= 2'd1;
      k     <= 2'd1;
      done  <= 1'b0;
      a_inv <= '{default: '{default: '0}};
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            r_cap <= '{'{R11_inv, R12_inv, R13_inv},
                       '{'0,      R22_inv, R23_inv},
                       '{'0,      '0,      R33_inv}};
            q_cap <= '{'{Q11, Q12, Q13}, '{Q21, Q22, Q23}, '{Q31, Q32, Q33}};
            i     <= 2'd1;
            j     <= 2'd1;
            k     <= 2'd1;
            state <= MAC;
          end
        end
        MAC: begin
          if (k == 2'd3) begin
            a_inv[i][j] <= mac_result;
            if (j == 2'd3) begin
              if (i == 2'd3) begin
                state <= DONE;
                done  <= 1'b1;
                i     <= 2'd1;
                j     <= 2'd1;
                k     <= 2'd1;
              end else begin
                // Next row starts on its diagonal element.
                i <= i + 2'd1;
                j <= 2'd1;
                k <= i + 2'd1;
              end
            end else begin
              j <= j + 2'd1;
              k <= i;
            end
          end else begin
            k <= k + 2'd1;
          end
        end
        DONE: begin
          if (!start) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign A11_inv = a_inv[1][1];
  assign A12_inv = a_inv[1][2];
  assign A13_inv = a_inv[1][3];
  assign A21_inv = a_inv[2][1];
  assign A22_inv = a_inv[2][2];
  assign A23_inv = a_inv[2][3];
  assign A31_inv = a_inv[3][1];
  assign A32_inv = a_inv[3][2];
  assign A33_inv = a_inv[3][3];

endmodule
